// File: rtl/fpu_ctrl_pkg.sv
// Shared opcode and state definitions for the FPU op scheduler.
// Imported by the scheduler and the top-level FPU wrapper.
package fpu_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    DIV_START,
    DIV_WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/fpu_op_scheduler.sv
// Sequences one op at a time onto the shared qadd/qmult/qdiv units
// and returns the captured result over a valid/ready response channel.
module fpu_op_scheduler
  import fpu_ctrl_pkg::*;
#(
  parameter int N           = 32,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_opcode,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  input  logic [N-1:0] add_c,
  input  logic [N-1:0] mul_c,
  output logic         div_start,
  input  logic         div_done,
  input  logic [N-1:0] div_q,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_err,
  output logic         busy
);

  localparam int CW = $clog2(DIV_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  sched_state_t state, state_nx;
  logic [1:0]    opc;
  logic [CW-1:0] cnt;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          unique case (1'b1)
            (req_opcode == OP_DIV): state_nx = DIV_START;
            (req_opcode == OP_BAD): state_nx = RESP;
            default:                state_nx = EXEC;
          endcase
        end
      end
      EXEC:      state_nx = RESP;
      DIV_START: state_nx = DIV_WAIT;
      DIV_WAIT: begin
        if (div_done || cnt == CNT_LAST)
          state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      opc        <= OP_ADD;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_a <= req_a;
            op_b <= req_b;
            opc  <= req_opcode;
            if (req_opcode == OP_BAD) begin
              rsp_result <= '0;
              rsp_err    <= 1'b1;
            end
          end
        end
        EXEC: begin
          rsp_result <= (opc == OP_MUL) ? mul_c : add_c;
          rsp_err    <= 1'b0;
        end
        DIV_START: cnt <= '0;
        DIV_WAIT: begin
          // done wins over a timeout landing on the same cycle
          if (div_done) begin
            rsp_result <= div_q;
            rsp_err    <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign div_start = (state == DIV_START);
  assign rsp_valid = (state == RESP);

endmodule
